// File: rtl/knight_pkg.sv
// Shared constants, FSM state type and one-hot move decode for the knight's-tour command path.
package knight_pkg;

    localparam logic [3:0] MOVE    = 4'h2;
    localparam logic [3:0] MOVE_FF = 4'h3;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    typedef enum logic [2:0] {IDLE, LEG1, WAIT1, LEG2, WAIT2} state_e;

    // leg=0: two-square move leg, leg=1: one-square fanfare leg. Lowest set bit wins.
    function automatic logic [15:0] decode_leg(input logic [7:0] mv, input logic leg);
        logic [2:0] b;
        logic [7:0] h1;
        logic [7:0] h2;
        b = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (mv[i]) b = 3'(i);
        h1 = HD_N;
        h2 = HD_W;
        case (b)
            3'd0: begin h1 = HD_N; h2 = HD_W; end
            3'd1: begin h1 = HD_N; h2 = HD_E; end
            3'd2: begin h1 = HD_W; h2 = HD_N; end
            3'd3: begin h1 = HD_W; h2 = HD_S; end
            3'd4: begin h1 = HD_S; h2 = HD_W; end
            3'd5: begin h1 = HD_S; h2 = HD_E; end
            3'd6: begin h1 = HD_E; h2 = HD_N; end
            default: begin h1 = HD_E; h2 = HD_S; end
        endcase
        return leg ? {MOVE_FF, h2, 4'd1} : {MOVE, h1, 4'd2};
    endfunction

endpackage

// File: rtl/tour_cmd_sequencer.sv
// Arbitrates cmd_proc between the UART path (idle pass-through) and tour playback,
// expanding each one-hot solver move into a move leg and a move-with-fanfare leg.
module tour_cmd_sequencer
    import knight_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        send_resp_o,
    output logic        tour_err
);

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    state_e      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [15:0] leg_cmd_q, leg_cmd_d;
    logic        tour_err_q, tour_err_d;
    logic        last;
    logic [15:0] leg_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mv_indx_q  <= 5'd0;
            leg_cmd_q  <= 16'h0000;
            tour_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            leg_cmd_q  <= leg_cmd_d;
            tour_err_q <= tour_err_d;
        end
    end

    assign last    = (mv_indx_q == LAST);
    // Decode is taken from the live solver output so a freshly bumped index is used at once.
    assign leg_now = decode_leg(move, state_q == LEG2);

    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        leg_cmd_d        = leg_cmd_q;
        tour_err_d       = 1'b0;
        cmd              = leg_cmd_q;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_ACK;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    mv_indx_d = 5'd0;
                    state_d   = LEG1;
                end
            end
            LEG1, LEG2: begin
                if (state_q == LEG2 && last) resp = RESP_DONE;
                if (move == 8'h00) begin
                    tour_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cmd       = leg_now;
                    cmd_rdy   = 1'b1;
                    leg_cmd_d = leg_now;
                    if (clr_cmd_rdy) begin
                        if (state_q == LEG1) begin
                            state_d = send_resp ? LEG2 : WAIT1;
                        end else if (!send_resp) begin
                            state_d = WAIT2;
                        end else if (last) begin
                            state_d = IDLE;
                        end else begin
                            mv_indx_d = 5'(mv_indx_q + 5'd1);
                            state_d   = LEG1;
                        end
                    end
                end
            end
            WAIT1: begin
                if (send_resp) state_d = LEG2;
            end
            WAIT2: begin
                if (last) resp = RESP_DONE;
                if (send_resp) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = 5'(mv_indx_q + 5'd1);
                        state_d   = LEG1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mv_indx     = mv_indx_q;
    assign tour_err    = tour_err_q;
    assign send_resp_o = send_resp;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Randomized self-checking bench: a cmd_proc responder plays whole tours against a
// table-driven model of the knight-move expansion.
module tb_tour_cmd_sequencer;

    localparam int NM = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        send_resp_o;
    logic        tour_err;

    logic [7:0]  move_tbl [NM];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign move = (int'(mv_indx) < NM) ? move_tbl[mv_indx] : 8'h00;

    tour_cmd_sequencer #(.NUM_MOVES(NM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .send_resp_o(send_resp_o), .tour_err(tour_err)
    );

    // Model: leg 0 goes two squares along the pair's main direction, leg 1 one square perpendicular.
    function automatic logic [15:0] exp_cmd(input logic [7:0] m, input int leg);
        logic [7:0] hd [4];
        int b, d1, d2;
        hd[0] = 8'h00; hd[1] = 8'h3F; hd[2] = 8'h7F; hd[3] = 8'hBF;  // N W S E
        b = -1;
        for (int i = 0; i < 8; i++)
            if (m[i] && b < 0) b = i;
        d1 = b / 2;
        if (d1 == 0 || d1 == 2) d2 = (b % 2) ? 3 : 1;
        else                    d2 = (b % 2) ? 2 : 0;
        if (leg == 0) return {4'h2, hd[d1], 4'h2};
        return {4'h3, hd[d2], 4'h1};
    endfunction

    task automatic fill_tbl();
        for (int i = 0; i < NM; i++) move_tbl[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (cmd !== 16'h1234) begin n_fail++; $display("FAIL rst_cmd got %h want 1234", cmd); end
        n_chk++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_rdy got %b want 1", cmd_rdy); end
        n_chk++; if (mv_indx !== 5'd0) begin n_fail++; $display("FAIL rst_mv_indx got %0d want 0", mv_indx); end
        n_chk++; if (tour_err !== 1'b0) begin n_fail++; $display("FAIL rst_tour_err got %b want 0", tour_err); end
        n_chk++; if (resp !== 8'hA5) begin n_fail++; $display("FAIL rst_resp got %h want a5", resp); end
        rst_n = 1'b1; cmd_rdy_UART = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthru();
        cmd_UART = 16'h3BF2; cmd_rdy_UART = 1'b1; #1;
        n_chk++; if (cmd !== 16'h3BF2 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL pass_cmd got %h/%b want 3bf2/1", cmd, cmd_rdy); end
        clr_cmd_rdy = 1'b1; #1;
        n_chk++; if (clr_cmd_rdy_UART !== 1'b1) begin n_fail++; $display("FAIL pass_clr got %b want 1", clr_cmd_rdy_UART); end
        @(negedge clk);
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; send_resp = 1'b1; #1;
        n_chk++; if (resp !== 8'hA5 || send_resp_o !== 1'b1) begin n_fail++; $display("FAIL pass_resp got %h/%b want a5/1", resp, send_resp_o); end
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    // Plays a tour; err_idx < NM marks a move index whose table entry is zero.
    task automatic test_tour(input int err_idx, input bit uart_pend);
        int n_ack, n_done, d;
        bit sim;
        logic [7:0] er;
        n_ack = 0; n_done = 0;
        if (err_idx < NM) move_tbl[err_idx] = 8'h00;
        cmd_UART = 16'hC0DE; cmd_rdy_UART = uart_pend;
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        for (int idx = 0; idx < NM; idx++) begin
            for (int leg = 0; leg < 2; leg++) begin
                if (idx == err_idx) begin
                    n_chk++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'(idx)) begin n_fail++; $display("FAIL err_leg got rdy=%b idx=%0d want 0/%0d", cmd_rdy, mv_indx, idx); end
                    @(negedge clk);
                    n_chk++; if (tour_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", tour_err); end
                    n_chk++; if (cmd_rdy !== uart_pend || cmd !== 16'hC0DE) begin n_fail++; $display("FAIL err_idle got %h/%b want c0de/%b", cmd, cmd_rdy, uart_pend); end
                    @(negedge clk);
                    n_chk++; if (tour_err !== 1'b0) begin n_fail++; $display("FAIL err_once got %b want 0", tour_err); end
                    cmd_rdy_UART = 1'b0;
                    return;
                end
                n_chk++;
                if (cmd_rdy !== 1'b1) begin
                    n_fail++; $display("FAIL leg_rdy idx=%0d leg=%0d got %b want 1", idx, leg, cmd_rdy);
                    cmd_rdy_UART = 1'b0;
                    return;
                end
                n_chk++; if (cmd !== exp_cmd(move_tbl[idx], leg)) begin n_fail++; $display("FAIL leg_cmd idx=%0d leg=%0d got %h want %h", idx, leg, cmd, exp_cmd(move_tbl[idx], leg)); end
                n_chk++; if (mv_indx !== 5'(idx)) begin n_fail++; $display("FAIL leg_idx got %0d want %0d", mv_indx, idx); end
                d = $urandom_range(0, 4);
                for (int k = 0; k < d; k++) begin
                    start_tour = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n_chk++; if (cmd_rdy !== 1'b1 || mv_indx !== 5'(idx)) begin n_fail++; $display("FAIL hold got rdy=%b idx=%0d want 1/%0d", cmd_rdy, mv_indx, idx); end
                end
                start_tour = 1'b0;
                er = (idx == NM - 1 && leg == 1) ? 8'hA5 : 8'h5A;
                clr_cmd_rdy = 1'b1;
                sim = ($urandom_range(0, 3) == 0);
                if (!sim) begin
                    #1;
                    n_chk++; if (clr_cmd_rdy_UART !== 1'b0) begin n_fail++; $display("FAIL uart_ack got %b want 0", clr_cmd_rdy_UART); end
                    @(negedge clk);
                    clr_cmd_rdy = 1'b0;
                    n_chk++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_drop got %b want 0", cmd_rdy); end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                send_resp = 1'b1; #1;
                n_chk++; if (resp !== er) begin n_fail++; $display("FAIL resp idx=%0d leg=%0d got %h want %h", idx, leg, resp, er); end
                if (resp === 8'h5A) n_ack++;
                if (resp === 8'hA5) n_done++;
                @(negedge clk);
                clr_cmd_rdy = 1'b0; send_resp = 1'b0;
            end
        end
        n_chk++; if (n_ack != 2 * NM - 1 || n_done != 1) begin n_fail++; $display("FAIL resp_counts got %0d/%0d want %0d/1", n_ack, n_done, 2 * NM - 1); end
        n_chk++; if (mv_indx !== 5'(NM - 1)) begin n_fail++; $display("FAIL end_idx got %0d want %0d", mv_indx, NM - 1); end
        n_chk++; if (cmd !== 16'hC0DE || cmd_rdy !== uart_pend) begin n_fail++; $display("FAIL end_idle got %h/%b want c0de/%b", cmd, cmd_rdy, uart_pend); end
        clr_cmd_rdy = 1'b1; #1;
        n_chk++; if (clr_cmd_rdy_UART !== 1'b1) begin n_fail++; $display("FAIL end_ack got %b want 1", clr_cmd_rdy_UART); end
        @(negedge clk);
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_tbl();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy k=%0d got %b want 1", k, cmd_rdy); end
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            if (k < 2) begin
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
            end
        end
        n_chk++; if (mv_indx !== 5'd1 || cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_wait1 got idx=%0d rdy=%b want 1/0", mv_indx, cmd_rdy); end
        cmd_UART = 16'h7777; cmd_rdy_UART = 1'b1; rst_n = 1'b0; #1;
        n_chk++; if (cmd_rdy !== 1'b1 || cmd !== 16'h7777) begin n_fail++; $display("FAIL mid_rst_mux got %h/%b want 7777/1", cmd, cmd_rdy); end
        n_chk++; if (mv_indx !== 5'd0) begin n_fail++; $display("FAIL mid_rst_idx got %0d want 0", mv_indx); end
        @(negedge clk);
        rst_n = 1'b1; cmd_rdy_UART = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0; start_tour = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        fill_tbl();
        test_reset();
        test_passthru();
        fill_tbl();
        move_tbl[0] = 8'h40;
        move_tbl[1] = 8'h05;
        test_tour(NM, 1'b1);
        fill_tbl();
        test_tour(NM, 1'b0);
        fill_tbl();
        test_tour(3, 1'b1);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
